pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
Central stall/flush scheduler for the five-stage pipeline. Generates the per-register stall bus consumed by the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers, and the global flush. Sequences multi-cycle divide in EXE with an internal countdown FSM. Resolves priority between exception flush, EXE divide stall and ID load-use stall, and supplies the exception redirect PC.

Parameters:
DIV_CYCLES, 34, total stalled cycles per divide (request cycle included); legal range 2..63
EXC_VECTOR, 32'h0000_0100, redirect PC for every exception except ERET
EXC_ERET, 5'h0E, exc_code value meaning ERET (redirect to cp0_epc)

Ports:
cpu_clk_50M  in  1  clock
cpu_rst_n  in  1  asynchronous active-low reset
stallreq_id  in  1  ID load-use hazard request
div_req  in  1  EXE holds a DIV/DIVU needing the divider
exc_req  in  1  MEM-stage exception/ERET committing this cycle
exc_code  in  5  cause code of exc_req
cp0_epc  in  32  current EPC from CP0
stall  out  4  [0] PC, [1] IF/ID, [2] ID/EXE, [3] EXE/MEM; 1 = hold
flush  out  1  clear all pipeline registers this edge
exc_newpc  out  32  redirect PC, valid while flush=1
div_busy  out  1  divider sequence in progress
div_done  out  1  one-cycle pulse: quotient/remainder valid, EXE may advance
perf_stall_cycles  out  32  see Optional Feature
perf_flush_cnt  out  32  see Optional Feature

Behaviour:
- Reset (cpu_rst_n=0, asynchronous): state=IDLE, cnt=0, perf counters=0. Outputs then evaluate as stall=4'b0000, flush=0, div_busy=0, div_done=0, exc_newpc=0. Reset mid-divide abandons the sequence with no div_done.
- FSM states: IDLE, DIV_BUSY. 6-bit down-counter cnt.
- IDLE & div_req & !exc_req: next state DIV_BUSY, cnt<=DIV_CYCLES-1.
- DIV_BUSY & cnt!=0: cnt decrements.
- DIV_BUSY & cnt==0: div_done=1, next state IDLE.
- Combinational priority, highest first:
  1. exc_req: flush=1, stall=4'b0000. exc_newpc = cp0_epc if exc_code==EXC_ERET, else EXC_VECTOR. Next state IDLE, cnt<=0, div_done suppressed (divide aborted).
  2. Divide stall, (IDLE & div_req) | (DIV_BUSY & cnt!=0): stall=4'b1111. EXE/MEM inserts a bubble on stall[3].
  3. stallreq_id: stall=4'b0111. Hold PC/IF/ID; ID/EXE inserts a NOP (stall[2]=1, stall[3]=0).
  4. Otherwise stall=4'b0000.
- div_done cycle: stall=4'b0000 unless stallreq_id; the divide instruction leaves EXE at that edge. div_req in the following cycle is treated as a new divide.
- Latency per divide: DIV_CYCLES stalled cycles, then 1 done cycle.
- div_busy=1 exactly while state==DIV_BUSY.
- stallreq_id during a divide is masked by the 4'b1111 stall. It re-evaluates once the divide completes.
- flush and stall never assert together. exc_newpc=0 when flush=0.

Optional Feature:
PIPE_STALL_PERF_EN.
- Defined: perf_stall_cycles increments on every cycle with stall[0]=1. perf_flush_cnt increments on every cycle with flush=1. Both are 32-bit, wrap modulo 2^32, and reset to 0 only by cpu_rst_n.
- Undefined: both ports are tied to 32'h0 and no counter flops are built.

Decomposition:
- Shared package pipe_ctrl_pkg: stall encodings STALL_NONE=4'b0000, STALL_ID=4'b0111, STALL_EXE=4'b1111; EXC_ERET and EXC_VECTOR defaults; FSM state enum.
- One natural sub-module, scu_div_timer: holds the state register and cnt, and produces div_busy, div_done and the divide-stall term, with an abort input driven by exc_req.

Test Plan:
- Reset mid-divide: assert cpu_rst_n=0 during DIV_BUSY at cnt=10 -> immediately stall=0, div_busy=0; no div_done after release.
- Divide, DIV_CYCLES=34: div_req held from cycle 0 -> stall=4'b1111 in cycles 0..33, div_done=1 and stall=0 in cycle 34, div_busy=1 in cycles 1..34.
- Load-use: stallreq_id=1 for one cycle, no div/exc -> stall=4'b0111 that cycle only.
- Exception mid-divide: exc_req=1, exc_code=5'h04 at cycle 10 of divide -> flush=1, stall=0, exc_newpc=32'h100; state IDLE next cycle; div_done never pulses.
- ERET: exc_req=1, exc_code=5'h0E, cp0_epc=32'hBFC0_0380 -> flush=1, exc_newpc=32'hBFC0_0380.
- Back-to-back divides with PIPE_STALL_PERF_EN, plus stallreq_id during the first -> second divide starts the cycle after div_done; perf_stall_cycles=68, perf_flush_cnt=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler: stall encodings,
// exception redirect defaults and the divide sequencer state type.
package pipe_ctrl_pkg;

    localparam logic [3:0] STALL_NONE = 4'b0000;
    localparam logic [3:0] STALL_ID   = 4'b0111;
    localparam logic [3:0] STALL_EXE  = 4'b1111;

    localparam logic [4:0]  EXC_ERET_DEF   = 5'h0E;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0100;
    localparam int          DIV_CYCLES_DEF = 34;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DIV_BUSY = 1'b1
    } div_state_e;

endpackage

// File: rtl/scu_div_timer.sv
// Divide sequencer: counts the stalled cycles of a multi-cycle DIV/DIVU in EXE
// and pulses div_done when the result is ready; abort drops the sequence.
module scu_div_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic div_req,
    input  logic abort,
    output logic div_busy,
    output logic div_done,
    output logic div_stall
);

    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

    div_state_e state_reg, state_next;
    logic [5:0] cnt_reg, cnt_next;
    logic       cnt_zero;

    assign cnt_zero  = (cnt_reg == 6'd0);
    assign div_busy  = (state_reg == ST_DIV_BUSY);
    assign div_done  = div_busy && cnt_zero && !abort;
    // The request cycle itself already stalls, so the total is DIV_CYCLES.
    assign div_stall = ((state_reg == ST_IDLE) && div_req) || (div_busy && !cnt_zero);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (abort) begin
            state_next = ST_IDLE;
            cnt_next   = 6'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (div_req) begin
                        state_next = ST_DIV_BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
                ST_DIV_BUSY: begin
                    if (!cnt_zero) begin
                        cnt_next = cnt_reg - 6'd1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 6'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the five-stage pipeline.
// Optional performance counters are built only when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          DIV_CYCLES = DIV_CYCLES_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [4:0]  EXC_ERET   = EXC_ERET_DEF
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        stallreq_id,
    input  logic        div_req,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] cp0_epc,
    output logic [3:0]  stall,
    output logic        flush,
    output logic [31:0] exc_newpc,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_cnt
);

    logic div_stall;

    scu_div_timer #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_timer (
        .clk       (cpu_clk_50M),
        .rst_n     (cpu_rst_n),
        .div_req   (div_req),
        .abort     (exc_req),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .div_stall (div_stall)
    );

    // An exception flush wins over every stall so the two never coincide.
    always_comb begin
        stall = STALL_NONE;
        if (exc_req) begin
            stall = STALL_NONE;
        end else if (div_stall) begin
            stall = STALL_EXE;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end
    end

    assign flush     = exc_req;
    assign exc_newpc = !exc_req              ? 32'h0 :
                       (exc_code == EXC_ERET) ? cp0_epc : EXC_VECTOR;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            perf_stall_reg <= 32'h0;
            perf_flush_reg <= 32'h0;
        end else begin
            if (stall[0]) perf_stall_reg <= perf_stall_reg + 32'd1;
            if (flush)    perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_reg;
    assign perf_flush_cnt    = perf_flush_reg;
`else
    assign perf_stall_cycles = 32'h0;
    assign perf_flush_cnt    = 32'h0;
`endif

endmodule
